wgt_rf_loader: RTL and testbench

//  Upstream controller for the NUM_FILTERS weight shift RFs (one per filter column).
//  - Accepts a weight stream from the weight buffer over valid/ready.
//  - Fills every RF in parallel, then rotates the stored weights circularly for cfg_reuse passes.
//  - Drives shared select_wgt / wgt_RF_shift_en and one data_in lane per RF.

---
 rtl/wgt_pkg.sv | 28 ++
 rtl/wgt_ldr_stall_ctr.sv | 41 ++++
 rtl/wgt_rf_loader.sv | 166 ++++++++++++++++
 tb/tb_wgt_rf_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wgt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wgt_pkg : shared types/constants for the weight RF loader slice.         |
// | Optional feature macro: WGT_LDR_STALL_CNT_EN.  Rev 1.0                   |
// +--------------------------------------------------------------------------+
package wgt_pkg;

    localparam int WGT_DATA_WIDTH  = 8;
    localparam int WGT_BUFFER_SIZE = 27;
    localparam int WGT_NUM_FILTERS = 32;
    localparam int WGT_REUSE_W     = 8;

    localparam int BEAT_W = $clog2(WGT_BUFFER_SIZE);
    localparam int LANE_W = WGT_NUM_FILTERS * WGT_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROTATE = 2'd2
    } wgt_state_e;

    // Keeps counter widths legal for degenerate depths of 1.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wgt_ldr_stall_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wgt_ldr_stall_ctr : saturating stall counter, built only when            |
// | WGT_LDR_STALL_CNT_EN is defined.  Rev 1.0                                |
// +--------------------------------------------------------------------------+
module wgt_ldr_stall_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != '1)) begin
            count_d = count_q + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/wgt_rf_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wgt_rf_loader : fills NUM_FILTERS weight shift RFs, then recirculates    |
// | them for cfg_reuse passes. Macro WGT_LDR_STALL_CNT_EN adds stall_cnt.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wgt_rf_loader
    import wgt_pkg::*;
#(
    parameter int DATA_WIDTH  = WGT_DATA_WIDTH,
    parameter int BUFFER_SIZE = WGT_BUFFER_SIZE,
    parameter int NUM_FILTERS = WGT_NUM_FILTERS,
    parameter int REUSE_W     = WGT_REUSE_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_start,
    input  logic [REUSE_W-1:0]                cfg_reuse,
    input  logic                              cfg_abort,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [NUM_FILTERS*DATA_WIDTH-1:0] s_data,
    input  logic                              compute_en,
    output logic                              select_wgt,
    output logic                              wgt_RF_shift_en,
    output logic [NUM_FILTERS*DATA_WIDTH-1:0] wgt_data,
    output logic                              busy,
    output logic                              load_done,
    output logic                              done
`ifdef WGT_LDR_STALL_CNT_EN
    ,
    output logic [15:0]                       stall_cnt
`endif
);

    localparam int c_beat_w = clog2_min1(BUFFER_SIZE);
    localparam int c_lane_w = NUM_FILTERS * DATA_WIDTH;

    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BUFFER_SIZE - 1);
    localparam logic [c_beat_w-1:0] c_beat_one  = c_beat_w'(1);
    localparam logic [REUSE_W-1:0]  c_reuse_one = REUSE_W'(1);

    wgt_state_e           state_q,      state_d;
    logic [c_beat_w-1:0]  beat_cnt_q,   beat_cnt_d;
    logic [REUSE_W-1:0]   pass_cnt_q,   pass_cnt_d;
    logic [REUSE_W-1:0]   reuse_q,      reuse_d;
    logic                 select_wgt_q, select_wgt_d;
    logic                 shift_en_q,   shift_en_d;
    logic [c_lane_w-1:0]  wgt_data_q,   wgt_data_d;
    logic                 load_done_q,  load_done_d;
    logic                 done_q,       done_d;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        reuse_d      = reuse_q;
        select_wgt_d = select_wgt_q;
        wgt_data_d   = wgt_data_q;
        shift_en_d   = 1'b0;
        load_done_d  = 1'b0;
        done_d       = 1'b0;

        // Abort overrides everything, including the strobe the current
        // beat/compute_en would otherwise have produced.
        if (cfg_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_d    = LOAD;
                        reuse_d    = (cfg_reuse == '0) ? c_reuse_one : cfg_reuse;
                        beat_cnt_d = '0;
                        pass_cnt_d = '0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        shift_en_d   = 1'b1;
                        select_wgt_d = 1'b1;
                        wgt_data_d   = s_data;
                        if (beat_cnt_q == c_last_beat) begin
                            beat_cnt_d  = '0;
                            load_done_d = 1'b1;
                            state_d     = ROTATE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + c_beat_one;
                        end
                    end
                end
                ROTATE: begin
                    if (compute_en) begin
                        shift_en_d   = 1'b1;
                        select_wgt_d = 1'b0;
                        if (beat_cnt_q == c_last_beat) begin
                            beat_cnt_d = '0;
                            pass_cnt_d = pass_cnt_q + c_reuse_one;
                            if (pass_cnt_q == (reuse_q - c_reuse_one)) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + c_beat_one;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            pass_cnt_q   <= '0;
            reuse_q      <= '0;
            select_wgt_q <= 1'b0;
            shift_en_q   <= 1'b0;
            wgt_data_q   <= '0;
            load_done_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            reuse_q      <= reuse_d;
            select_wgt_q <= select_wgt_d;
            shift_en_q   <= shift_en_d;
            wgt_data_q   <= wgt_data_d;
            load_done_q  <= load_done_d;
            done_q       <= done_d;
        end
    end

    assign s_ready         = (state_q == LOAD);
    assign busy            = (state_q != IDLE);
    assign select_wgt      = select_wgt_q;
    assign wgt_RF_shift_en = shift_en_q;
    assign wgt_data        = wgt_data_q;
    assign load_done       = load_done_q;
    assign done            = done_q;

`ifdef WGT_LDR_STALL_CNT_EN
    logic stall_clr;
    logic stall_inc;

    assign stall_clr = (state_q == IDLE) && cfg_start && !cfg_abort;
    assign stall_inc = (state_q == LOAD) && !s_valid;

    wgt_ldr_stall_ctr #(
        .CNT_W (16)
    ) u_stall_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (stall_clr),
        .i_inc   (stall_inc),
        .o_count (stall_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_wgt_rf_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wgt_rf_loader : randomized scoreboard bench for wgt_rf_loader.        |
// | Honours WGT_LDR_STALL_CNT_EN.  Rev 1.0                                   |
// +--------------------------------------------------------------------------+
module tb_wgt_rf_loader;
    import wgt_pkg::*;

    localparam int BS = WGT_BUFFER_SIZE;
    localparam int LW = LANE_W;
    localparam int RW = WGT_REUSE_W;

    typedef struct {
        logic          sel;
        logic [LW-1:0] data;
        logic          ld;
        logic          dn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [RW-1:0] cfg_reuse = '0;
    logic          cfg_abort = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [LW-1:0] s_data = '0;
    logic          compute_en = 1'b0;
    logic          select_wgt;
    logic          wgt_RF_shift_en;
    logic [LW-1:0] wgt_data;
    logic          busy;
    logic          load_done;
    logic          done;
`ifdef WGT_LDR_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    wgt_rf_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_reuse       (cfg_reuse),
        .cfg_abort       (cfg_abort),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .compute_en      (compute_en),
        .select_wgt      (select_wgt),
        .wgt_RF_shift_en (wgt_RF_shift_en),
        .wgt_data        (wgt_data),
        .busy            (busy),
        .load_done       (load_done),
        .done            (done)
`ifdef WGT_LDR_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    logic [LW-1:0] rf[$];
    logic [LW-1:0] taps[$];
    int            checks = 0;
    int            failures = 0;
    int            strobes = 0;
    int            m_phase = 0;
    int            m_beats = 0;
    int            m_rot = 0;
    int            m_reuse = 1;
    exp_t          mon_e;
    logic [LW-1:0] mon_rv;
    logic          mon_bad;

    function automatic logic [LW-1:0] rand_lane();
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < (LW + 31) / 32; i++) begin
            r = (r << 32) | LW'($urandom);
        end
        return r;
    endfunction

    // Monitor: pops one expectation per strobe; the bench also plays the RF.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (wgt_RF_shift_en) begin
                strobes++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe n=%0d sel=%b ld=%b dn=%b required=none",
                             strobes, select_wgt, load_done, done);
                end else begin
                    mon_e = sb.pop_front();
                    if (select_wgt) begin
                        rf.push_back(wgt_data);
                        if (rf.size() > BS) void'(rf.pop_front());
                        mon_rv = wgt_data;
                    end else begin
                        mon_rv = (rf.size() > 0) ? rf.pop_front() : 'x;
                        rf.push_back(mon_rv);
                    end
                    mon_bad = (select_wgt !== mon_e.sel) || (load_done !== mon_e.ld) ||
                              (done !== mon_e.dn) || (mon_rv !== mon_e.data);
                    if (mon_bad) begin
                        failures++;
                        $display("FAIL strobe n=%0d sel=%b/%b ld=%b/%b dn=%b/%b tap=%h/%h (actual/required)",
                                 strobes, select_wgt, mon_e.sel, load_done, mon_e.ld,
                                 done, mon_e.dn, mon_rv[31:0], mon_e.data[31:0]);
                    end
                end
            end else if (load_done || done) begin
                failures++;
                $display("FAIL spurious_pulse load_done=%b done=%b required=0/0", load_done, done);
            end
        end
    end

    // One cycle of stimulus; the model advances to the post-edge state.
    task automatic cyc(input logic st, input logic [RW-1:0] ru, input logic ab,
                       input logic v, input logic ce);
        checks++;
        if (s_ready !== (m_phase == 1) || busy !== (m_phase != 0)) begin
            failures++;
            $display("FAIL handshake s_ready=%b busy=%b required=%b/%b",
                     s_ready, busy, (m_phase == 1), (m_phase != 0));
        end
        cfg_start  = st;
        cfg_reuse  = ru;
        cfg_abort  = ab;
        s_valid    = v;
        compute_en = ce;
        if (v) s_data = rand_lane();
        if (ab) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_phase = 1;
                    m_reuse = (ru == '0) ? 1 : int'(ru);
                    m_beats = 0;
                    m_rot   = 0;
                    taps.delete();
                end
                1: if (v) begin
                    sb.push_back('{sel: 1'b1, data: s_data, ld: (m_beats == BS - 1), dn: 1'b0});
                    taps.push_back(s_data);
                    m_beats++;
                    if (m_beats == BS) m_phase = 2;
                end
                2: if (ce) begin
                    sb.push_back('{sel: 1'b0, data: taps[m_rot % BS], ld: 1'b0,
                                   dn: (m_rot == m_reuse * BS - 1)});
                    m_rot++;
                    if (m_rot == m_reuse * BS) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({s_ready, busy, select_wgt, wgt_RF_shift_en, load_done, done} !== 6'b0 ||
            wgt_data !== '0) begin
            failures++;
            $display("FAIL %s outs=%b data=%h required=0", name,
                     {s_ready, busy, select_wgt, wgt_RF_shift_en, load_done, done}, wgt_data[31:0]);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0, $urandom_range(0, 1) == 1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    // vpat: 0 valid held, 1 toggling, 2 random. cpat: 0 held, 1 random.
    task automatic run_job(input logic [RW-1:0] ru, input int vpat, input int cpat,
                           input int abort_beat, input int rst_rot);
        int k;
        int guard;
        logic v;
        k = 0;
        guard = 0;
        cyc(1'b1, ru, 1'b0, 1'b0, 1'b0);
        while (m_phase == 1 && guard < 2000) begin
            v = (vpat == 0) ? 1'b1 : (vpat == 1) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
            if (abort_beat > 0 && v && m_beats == abort_beat - 1) begin
                cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
                return;
            end
            cyc($urandom_range(0, 3) == 0, RW'($urandom), 1'b0, v, $urandom_range(0, 1) == 1);
            k++;
            guard++;
        end
`ifdef WGT_LDR_STALL_CNT_EN
        if (vpat == 1) begin
            checks++;
            if (stall_cnt !== 16'd26) begin
                failures++;
                $display("FAIL stall_cnt actual=%0d required=26", stall_cnt);
            end
        end
`endif
        while (m_phase == 2 && guard < 4000) begin
            if (rst_rot >= 0 && m_rot == rst_rot) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("async_reset");
                sb.delete();
                rf.delete();
                m_phase = 0;
                @(posedge clk);
                #1;
                return;
            end
            cyc($urandom_range(0, 3) == 0, RW'($urandom), 1'b0, 1'b0,
                (cpat == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
            guard++;
        end
        checks++;
        if (m_phase != 0) begin
            failures++;
            $display("FAIL job_timeout phase=%0d required=0", m_phase);
            m_phase = 0;
        end
    endtask

    initial begin
        #1;
        check_zero("reset_state");
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("after_reset");

        cyc(1'b1, RW'(2), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

        run_job(RW'(2), 0, 0, -1, -1);
        drain();
        run_job(RW'(1), 1, 1, -1, -1);
        drain();
        run_job(RW'(0), 2, 1, -1, -1);
        drain();
        run_job(RW'(3), 0, 1, 10, -1);
        drain();
        run_job(RW'(1), 0, 0, -1, -1);
        drain();

        run_job(RW'(2), 2, 1, -1, 12);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_zero("post_reset_idle");

        for (int j = 0; j < 4; j++) run_job(RW'($urandom_range(0, 3)), 2, 1, -1, -1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
